// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with arbitrary depth, optional first-word-fall-through read,
// programmable almost flags, occupancy output, synchronous flush and sticky error flags.
module sync_fifo_flex #(
    parameter int DATA_WIDTH    = 8,
    parameter int DEPTH         = 16,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = DEPTH - 2,
    parameter int AEMPTY_THRESH = 2,
    localparam int LW           = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [LW-1:0]         level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         w_ptr;
    logic [PW-1:0]         r_ptr;
    logic [LW-1:0]         count;
    logic                  rd_acc;
    logic                  wr_acc;

    // Non-power-of-two depth: wrap by explicit compare rather than by pointer overflow.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty        = (count == '0);
    assign full         = (count == LW'(DEPTH));
    assign almost_full  = (count >= LW'(AFULL_THRESH));
    assign almost_empty = (count <= LW'(AEMPTY_THRESH));
    assign level        = count;

    assign rd_acc = rd_en & ~empty & ~flush;
    assign wr_acc = wr_en & ~flush & (~full | rd_acc);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) w_ptr <= next_ptr(w_ptr);
            if (rd_acc) r_ptr <= next_ptr(r_ptr);
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (wr_en && full && !rd_acc) overflow  <= 1'b1;
            if (rd_en && empty)           underflow <= 1'b1;
        end
    end

    // NOTE: the storage array has no reset so it maps onto plain RAM; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[w_ptr] <= wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign rdata = mem[r_ptr];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)      rdata_q <= '0;
                else if (flush)  rdata_q <= '0;
                else if (rd_acc) rdata_q <= mem[r_ptr];
            end
            assign rdata = rdata_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Scoreboard bench: a registered-read and a fall-through FIFO share stimulus and are
// compared against a queue-based model of the FIFO rules.
module tb_sync_fifo_flex;

    localparam int DW    = 8;
    localparam int DEPTH = 5;
    localparam int AF    = 3;
    localparam int AE    = 1;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wdata;
    logic          rd_en;

    logic [DW-1:0] rdata0, rdata1;
    logic          full0, empty0, af0, ae0, ovf0, unf0;
    logic          full1, empty1, af1, ae1, ovf1, unf1;
    logic [LW-1:0] level0, level1;

    sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0),
                     .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut_reg (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wdata(wdata),
        .rd_en(rd_en), .rdata(rdata0), .full(full0), .empty(empty0),
        .almost_full(af0), .almost_empty(ae0), .level(level0),
        .overflow(ovf0), .underflow(unf0));

    sync_fifo_flex #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1),
                     .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)) dut_fwft (
        .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .wdata(wdata),
        .rd_en(rd_en), .rdata(rdata1), .full(full1), .empty(empty1),
        .almost_full(af1), .almost_empty(ae1), .level(level1),
        .overflow(ovf1), .underflow(unf1));

    always #5 clk = ~clk;

    // Reference model: stored entries, sticky flags, and expected registered-read words.
    logic [DW-1:0] q[$];
    logic [DW-1:0] sb_q[$];
    logic          m_ovf, m_unf;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: compares both DUTs on every falling edge, away from the active edge.
    always @(negedge clk) begin
        int unsigned lvl;
        lvl = q.size();
        check("level0", 32'(level0), lvl);
        check("level1", 32'(level1), lvl);
        check("empty0", 32'(empty0), 32'(lvl == 0));
        check("empty1", 32'(empty1), 32'(lvl == 0));
        check("full0", 32'(full0), 32'(lvl == DEPTH));
        check("full1", 32'(full1), 32'(lvl == DEPTH));
        check("afull0", 32'(af0), 32'(lvl >= AF));
        check("afull1", 32'(af1), 32'(lvl >= AF));
        check("aempty0", 32'(ae0), 32'(lvl <= AE));
        check("aempty1", 32'(ae1), 32'(lvl <= AE));
        check("overflow0", 32'(ovf0), 32'(m_ovf));
        check("overflow1", 32'(ovf1), 32'(m_ovf));
        check("underflow0", 32'(unf0), 32'(m_unf));
        check("underflow1", 32'(unf1), 32'(m_unf));
        if (sb_q.size() > 0) check("rdata_reg", 32'(rdata0), 32'(sb_q.pop_front()));
        if (lvl != 0) check("rdata_fwft", 32'(rdata1), 32'(q[0]));
    end

    // One clock of stimulus; entered and left just after a falling edge.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
        logic ra, wa;
        wr_en = w; wdata = d; rd_en = r; flush = f;
        ra = r && (q.size() != 0) && !f;
        wa = w && !f && ((q.size() < DEPTH) || ra);
        @(posedge clk);
        if (f) begin
            q.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
            sb_q.push_back('0);
        end else begin
            if (w && q.size() == DEPTH && !ra) m_ovf = 1'b1;
            if (r && q.size() == 0)            m_unf = 1'b1;
            if (ra) sb_q.push_back(q.pop_front());
            if (wa) q.push_back(d);
        end
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
    endtask

    // Asynchronous reset asserted mid-cycle; state must clear without a clock edge.
    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
        #1;
        q.delete();
        sb_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        check("rst_level0", 32'(level0), 0);
        check("rst_level1", 32'(level1), 0);
        check("rst_empty", 32'(empty0 & empty1), 1);
        check("rst_flags", 32'({ovf0, unf0, ovf1, unf1, full0, full1}), 0);
        check("rst_rdata0", 32'(rdata0), 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wdata = '0;
        m_ovf = 1'b0; m_unf = 1'b0;
        #1;
        check("init_level", 32'(level0), 0);
        check("init_empty_aempty", 32'({empty0, ae0, empty1, ae1}), 32'hF);
        check("init_full_afull", 32'({full0, af0, full1, af1}), 0);
        check("init_rdata0", 32'(rdata0), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill, refused sixth write, drain in order.
        for (int i = 0; i < 5; i++) step(1'b1, 8'h11 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h99, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);

        // Pointer wrap.
        for (int i = 0; i < 3; i++) step(1'b1, 8'h20 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush clears sticky flags, then simultaneous read/write while full.
        step(1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 8'hB0 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'h55, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Read while empty, then read+write while empty.
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush at level 3 with overflow set and both requests high.
        for (int i = 0; i < 5; i++) step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        step(1'b1, 8'hEE, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b1, 8'hDD, 1'b1, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b1, 8'h42, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);

        // Reset in the middle of a burst; first write afterwards lands at slot 0.
        for (int i = 0; i < 3; i++) step(1'b1, 8'h60 + 8'(i), 1'b1, 1'b0);
        async_reset();
        for (int i = 0; i < 4; i++) step(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

        // Randomized traffic with phases biased toward full and toward empty.
        for (int i = 0; i < 3000; i++) begin
            int unsigned wp, rp;
            logic w, r, f;
            case ((i / 200) % 3)
                0:       begin wp = 80; rp = 30; end
                1:       begin wp = 30; rp = 80; end
                default: begin wp = 60; rp = 60; end
            endcase
            w = ($urandom_range(99) < wp);
            r = ($urandom_range(99) < rp);
            f = ($urandom_range(63) == 0);
            step(w, 8'($urandom), r, f);
            if ($urandom_range(499) == 0) async_reset();
        end

        step(1'b0, 8'h00, 1'b0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
